// File: rtl/sram_bist.sv
// sram_bist: march-style self-test engine for an external async SRAM.
// Ports: start/loop/mode/seed control a run; sram_* drive the SRAM pins
// (bus tristate resolved above); busy/done/err/err_count/fail_*/pass_count
// report status and the first mismatch of the current run.
module sram_bist #(
  parameter int ADDR_W      = 18,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              loop,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] seed,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dq_o,
  output logic              sram_dq_oe,
  input  logic [DATA_W-1:0] sram_dq_i,
  output logic              sram_cs_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_exp,
  output logic [DATA_W-1:0] fail_got,
  output logic [15:0]       pass_count
);

  localparam int CW = $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, W_SETUP, W_PULSE, W_HOLD,
    TURN, R_ADDR, R_WAIT, FIN
  } state_t;

  state_t state, state_nx;

  logic [ADDR_W-1:0] addr;
  logic [CW-1:0]     cnt;
  logic              phase;
  logic [1:0]        mode_q;
  logic [DATA_W-1:0] seed_q;

  logic [31:0]       a32;
  logic [DATA_W-1:0] a_d;
  logic [DATA_W-1:0] pat;
  logic [DATA_W-1:0] word;
  logic              last_addr;
  logic              cnt_done;
  logic              sample;
  logic              miss;
  logic              clr;

  always_comb begin
    a32 = 32'(addr);
    a_d = DATA_W'(addr);
    pat = seed_q;
    unique case (mode_q)
      2'd0:    pat = seed_q + a_d;
      2'd1:    pat = addr[0] ? ~seed_q : seed_q;
      2'd2:    pat = seed_q ^ (DATA_W'(1) << (a32 % 32'(DATA_W)));
      default: pat = seed_q ^ a_d;
    endcase
    word = phase ? ~pat : pat;
  end

  assign last_addr = &addr;
  assign cnt_done  = (cnt == CNT_LAST);
  assign sample    = (state == R_WAIT) && cnt_done;
  assign miss      = sample && (sram_dq_i != word);
  // error state is wiped both on a fresh start and on a loop restart
  assign clr       = ((state == IDLE) && start) ||
                     ((state == FIN) && loop);

  always_comb begin
    state_nx   = state;
    sram_dq_oe = 1'b0;
    sram_oe_n  = 1'b1;
    sram_we_n  = 1'b1;
    unique case (state)
      IDLE: if (start) state_nx = W_SETUP;
      W_SETUP: begin
        sram_dq_oe = 1'b1;
        state_nx   = W_PULSE;
      end
      W_PULSE: begin
        sram_dq_oe = 1'b1;
        sram_we_n  = 1'b0;
        if (cnt_done) state_nx = W_HOLD;
      end
      W_HOLD: begin
        sram_dq_oe = 1'b1;
        state_nx   = last_addr ? TURN : W_SETUP;
      end
      TURN: state_nx = R_ADDR;
      R_ADDR: begin
        sram_oe_n = 1'b0;
        state_nx  = R_WAIT;
      end
      R_WAIT: begin
        sram_oe_n = 1'b0;
        if (cnt_done) begin
          if (!last_addr) state_nx = R_ADDR;
          else if (!phase) state_nx = W_SETUP;
          else state_nx = FIN;
        end
      end
      FIN: state_nx = loop ? W_SETUP : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign sram_addr = addr;
  assign sram_dq_o = sram_dq_oe ? word : '0;
  assign sram_cs_n = (state == IDLE);
  assign busy      = (state != IDLE);
  assign done      = (state == FIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      addr       <= '0;
      cnt        <= '0;
      phase      <= 1'b0;
      mode_q     <= 2'd0;
      seed_q     <= '0;
      err        <= 1'b0;
      err_count  <= 16'd0;
      fail_addr  <= '0;
      fail_exp   <= '0;
      fail_got   <= '0;
      pass_count <= 16'd0;
    end else begin
      state <= state_nx;

      if ((state == W_PULSE || state == R_WAIT) && !cnt_done)
        cnt <= cnt + 1'b1;
      else
        cnt <= '0;

      // address wraps to 0 after the last word of each sweep
      if (state == W_HOLD || sample)
        addr <= addr + 1'b1;
      else if (clr)
        addr <= '0;

      if (sample && last_addr)
        phase <= ~phase;
      else if (clr)
        phase <= 1'b0;

      if ((state == IDLE) && start) begin
        mode_q <= mode;
        seed_q <= seed;
      end

      if (state == FIN) begin
        pass_count <= pass_count + 16'd1;
        if (loop) seed_q <= seed_q + DATA_W'(1);
      end

      if (clr) begin
        err       <= 1'b0;
        err_count <= 16'd0;
        fail_addr <= '0;
        fail_exp  <= '0;
        fail_got  <= '0;
      end else if (miss) begin
        err <= 1'b1;
        if (err_count != 16'hFFFF)
          err_count <= err_count + 16'd1;
        if (!err) begin
          fail_addr <= addr;
          fail_exp  <= word;
          fail_got  <= sram_dq_i;
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_bist.sv
// tb_sram_bist: randomized bench for sram_bist with an SRAM model,
// fault injection, a pin-protocol monitor and a pattern reference model.
module tb_sram_bist;

  localparam int AW      = 4;
  localparam int DW      = 8;
  localparam int WC      = 3;
  localparam int DEPTH   = 1 << AW;
  localparam int RUN_LEN = 2 * DEPTH * (2 * WC + 3) + 3;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          loop  = 1'b0;
  logic [1:0]    mode  = 2'd0;
  logic [DW-1:0] seed  = '0;

  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_dq_o;
  logic          sram_dq_oe;
  logic [DW-1:0] sram_dq_i;
  logic          sram_cs_n;
  logic          sram_oe_n;
  logic          sram_we_n;
  logic          busy;
  logic          done;
  logic          err;
  logic [15:0]   err_count;
  logic [AW-1:0] fail_addr;
  logic [DW-1:0] fail_exp;
  logic [DW-1:0] fail_got;
  logic [15:0]   pass_count;

  sram_bist #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .WAIT_CYCLES(WC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .loop(loop),
    .mode(mode),
    .seed(seed),
    .sram_addr(sram_addr),
    .sram_dq_o(sram_dq_o),
    .sram_dq_oe(sram_dq_oe),
    .sram_dq_i(sram_dq_i),
    .sram_cs_n(sram_cs_n),
    .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n),
    .busy(busy),
    .done(done),
    .err(err),
    .err_count(err_count),
    .fail_addr(fail_addr),
    .fail_exp(fail_exp),
    .fail_got(fail_got),
    .pass_count(pass_count)
  );

  always #5 clk = ~clk;

  // SRAM model: stores what is written, reads back with stuck-at-0 bits
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] sa0 [DEPTH];

  always @(posedge clk)
    if (!sram_cs_n && !sram_we_n) mem[sram_addr] <= sram_dq_o;

  assign sram_dq_i = sram_oe_n ? '0 :
                     (mem[sram_addr] & ~sa0[sram_addr]);

  // pin-protocol monitor; completed writes go to wr_q
  logic [AW+DW-1:0] wr_q [$];
  int               viol  = 0;
  int               we_len = 0;
  logic             p_we  = 1'b1;
  logic             p_oe  = 1'b0;
  logic [AW-1:0]    p_a   = '0;
  logic [DW-1:0]    p_d   = '0;
  logic [AW-1:0]    ref_a = '0;
  logic [DW-1:0]    ref_d = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      we_len <= 0;
      p_we   <= 1'b1;
    end else begin
      p_we <= sram_we_n;
      p_a  <= sram_addr;
      p_d  <= sram_dq_o;
      p_oe <= sram_dq_oe;
      if (!sram_oe_n && (sram_dq_oe || !sram_we_n))
        viol <= viol + 1;
      if (sram_cs_n != !busy)
        viol <= viol + 1;
      if (!sram_we_n) begin
        we_len <= we_len + 1;
        if (p_we) begin
          ref_a <= sram_addr;
          ref_d <= sram_dq_o;
          if (p_a != sram_addr || p_d != sram_dq_o || !p_oe)
            viol <= viol + 1;
        end else if (sram_addr != ref_a || sram_dq_o != ref_d) begin
          viol <= viol + 1;
        end
      end else if (!p_we) begin
        if (we_len != WC || sram_addr != ref_a ||
            sram_dq_o != ref_d || !sram_dq_oe)
          viol <= viol + 1;
        wr_q.push_back({ref_a, ref_d});
        we_len <= 0;
      end
    end
  end

  int n_chk    = 0;
  int n_pass   = 0;
  int exp_pass = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [DW-1:0] pat(input logic [1:0] m,
                                        input logic [DW-1:0] s,
                                        input int a);
    logic [DW-1:0] av;
    av = DW'(a);
    case (m)
      2'd0:    return s + av;
      2'd1:    return (a % 2 == 1) ? ~s : s;
      2'd2:    return s ^ (DW'(1) << (a % DW));
      default: return s ^ av;
    endcase
  endfunction

  task automatic run(input logic [1:0] m, input logic [DW-1:0] s,
                     input int runs, input string tag);
    int            base, vbase, cyc, dn, nerr, bad;
    logic [AW-1:0] fa;
    logic [DW-1:0] fe, fg, e, g, ls;
    base  = wr_q.size();
    vbase = viol;
    @(negedge clk);
    mode  = m;
    seed  = s;
    loop  = (runs > 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    dn  = 0;
    while (busy && cyc < 4 * RUN_LEN) begin
      cyc++;
      if (done) dn++;
      else if (dn == runs - 1) loop = 1'b0;
      // mid-run input changes and a stray start must be ignored
      if (cyc == 40) begin
        mode  = 2'($urandom);
        seed  = DW'($urandom);
        start = 1'b1;
      end
      if (cyc == 41) start = 1'b0;
      @(negedge clk);
    end
    loop = 1'b0;
    exp_pass += runs;
    check({tag, "_len"}, cyc, runs * RUN_LEN);
    check({tag, "_dones"}, dn, runs);
    check({tag, "_pass"}, pass_count, 16'(exp_pass));

    ls   = s + DW'(runs - 1);
    nerr = 0;
    fa   = '0;
    fe   = '0;
    fg   = '0;
    for (int ph = 0; ph < 2; ph++) begin
      for (int a = 0; a < DEPTH; a++) begin
        e = pat(m, ls, a);
        if (ph == 1) e = ~e;
        g = e & ~sa0[a];
        if (g != e) begin
          if (nerr == 0) begin
            fa = AW'(a);
            fe = e;
            fg = g;
          end
          nerr++;
        end
      end
    end
    check({tag, "_err"}, err, nerr != 0);
    check({tag, "_errcnt"}, err_count, nerr);
    check({tag, "_faddr"}, fail_addr, fa);
    check({tag, "_fexp"}, fail_exp, fe);
    check({tag, "_fgot"}, fail_got, fg);

    check({tag, "_nwr"}, wr_q.size() - base, runs * 2 * DEPTH);
    bad = 0;
    for (int i = 0; i < runs * 2 * DEPTH && base + i < wr_q.size(); i++) begin
      e = pat(m, s + DW'(i / (2 * DEPTH)), i % DEPTH);
      if ((i / DEPTH) % 2 == 1) e = ~e;
      if (wr_q[base + i] != {AW'(i % DEPTH), e}) bad++;
    end
    check({tag, "_wrdata"}, bad, 0);

    bad = 0;
    for (int a = 0; a < DEPTH; a++)
      if (mem[a] !== ~pat(m, ls, a)) bad++;
    check({tag, "_mem"}, bad, 0);
    check({tag, "_proto"}, viol - vbase, 0);
  endtask

  initial begin
    logic [DW-1:0] s;
    for (int a = 0; a < DEPTH; a++) sa0[a] = '0;
    repeat (3) @(negedge clk);
    check("rst_pins", {sram_cs_n, sram_oe_n, sram_we_n, sram_dq_oe},
          4'b1110);
    check("rst_bus", {sram_addr, sram_dq_o}, 0);
    check("rst_stat", {busy, done, err}, 0);
    check("rst_cnt", {err_count, pass_count}, 0);
    check("rst_fail", {fail_addr, fail_exp, fail_got}, 0);
    rst_n = 1'b1;

    run(2'd0, 8'h10, 1, "ideal");

    sa0[5] = 8'h08;
    run(2'd0, 8'h10, 1, "sa5");
    check("sa5_cnt1", err_count, 1);
    check("sa5_addr5", fail_addr, 5);
    check("sa5_expEA", fail_exp, 8'hEA);
    check("sa5_gotE2", fail_got, 8'hE2);
    sa0[5] = '0;

    for (int a = 0; a < DEPTH; a++) sa0[a] = 8'hFF;
    s = DW'($urandom_range(1, 254));
    run(2'd1, s, 1, "sa_all");
    check("sa_all_cnt32", err_count, 32);
    check("sa_all_addr0", fail_addr, 0);
    check("sa_all_seed", fail_exp, s);

    for (int m = 0; m < 4; m++) begin
      for (int a = 0; a < DEPTH; a++)
        sa0[a] = ($urandom_range(0, 3) == 0) ?
                 DW'(1 << $urandom_range(0, DW - 1)) : '0;
      run(2'(m), DW'($urandom), 1, $sformatf("rnd%0d", m));
    end
    for (int a = 0; a < DEPTH; a++) sa0[a] = '0;

    run(2'($urandom), DW'($urandom), 3, "loop");

    @(negedge clk);
    mode  = 2'd2;
    seed  = DW'($urandom);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 100 && sram_we_n; i++) @(negedge clk);
    check("midrst_we_low", sram_we_n, 0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_pins", {sram_cs_n, sram_oe_n, sram_we_n, sram_dq_oe},
          4'b1110);
    check("midrst_stat", {busy, done, pass_count}, 0);
    exp_pass = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run(2'($urandom), DW'($urandom), 1, "after_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sram_bist.md
# sram_bist

Parametrised built-in self-test engine for an external asynchronous SRAM. On `start` it writes a selectable data pattern to every address, reads it back and compares, then repeats with the bitwise-inverted pattern. It records error count and first-failure details, and can loop indefinitely with an advancing seed. It sits between the board-level SRAM pins (tristate resolved in the top level) and the debug/LED outputs.

## Interface
- `ADDR_W`, 18, SRAM address width; depth = 2^ADDR_W words.
- `DATA_W`, 16, SRAM data width (≥ 2).
- `WAIT_CYCLES`, 1, clk cycles of WE-low pulse and of read access wait (≥ 1).
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `start`  in  1  begin a run; sampled only in IDLE.
- `loop`  in  1  sampled at end of run; 1 = auto-restart.
- `mode`  in  2  pattern select; latched at start.
- `seed`  in  DATA_W  pattern seed; latched at start.
- `sram_addr`  out  ADDR_W  SRAM address.
- `sram_dq_o`  out  DATA_W  write data.
- `sram_dq_oe`  out  1  1 = top level drives `sram_dq_o` onto the bus.
- `sram_dq_i`  in  DATA_W  bus read data.
- `sram_cs_n`, `sram_oe_n`, `sram_we_n`  out  1 each  active-low SRAM strobes.
- `busy`  out  1  run in progress.
- `done`  out  1  one-cycle pulse at end of each run.
- `err`  out  1  sticky: ≥ 1 mismatch since last start.
- `err_count`  out  16  mismatch count, saturating at 0xFFFF.
- `fail_addr`, `fail_exp`, `fail_got`  out  ADDR_W / DATA_W / DATA_W  first mismatch of the run.
- `pass_count`  out  16  completed runs since reset; wraps.

## Operation
- Pattern `p(a)` with latched seed `s`, where `a` is zero-extended or truncated to DATA_W:
  - mode 0: `s + a` mod 2^DATA_W.
  - mode 1: `a[0] ? ~s : s` (checkerboard).
  - mode 2: `s ^ (1 << (a mod DATA_W))` (walking one).
  - mode 3: `s ^ a` (address-in-data).
- Phase 0 uses `p(a)`; phase 1 uses `~p(a)`.
- States: IDLE → W_SETUP → W_PULSE → W_HOLD → (next addr: W_SETUP | last addr: TURN) → R_ADDR → R_WAIT → (next addr: R_ADDR | last: phase 0 → W_SETUP with phase 1; phase 1 → FIN) → FIN → IDLE, or W_SETUP if `loop`.
- In W_SETUP, addr and data are driven with `dq_oe`=1, `we_n`=1, `oe_n`=1.
- In W_PULSE, `we_n`=0 for WAIT_CYCLES cycles.
- In W_HOLD, `we_n`=1 while addr and data are held.
- TURN: one cycle with `dq_oe`=0, `oe_n`=1, `we_n`=1.
- In R_ADDR, the address is driven with `oe_n`=0 and `dq_oe`=0.
- R_WAIT lasts WAIT_CYCLES cycles. `sram_dq_i` is compared on the final R_WAIT edge.
- `oe_n`=0 is never simultaneous with `dq_oe`=1 or `we_n`=0. This holds in every state.
- `cs_n`=0 whenever busy; `cs_n`=1 in IDLE.
- Addresses ascend from 0 to 2^ADDR_W−1 in both phases. Increments wrap, and the last address is detected by an all-ones compare.
- On a mismatch:
  - `err_count` increments unless it is already 0xFFFF.
  - `err` is set.
  - If this is the first mismatch of the run, `fail_*` capture address, expected value and read value.
- On start (from IDLE), all of the following happen:
  - `err`, `err_count` and `fail_*` clear.
  - `mode` and `seed` are latched.
  - Address goes to 0, phase to 0.
  - `busy` rises.
- FIN:
  - `done`=1 for one cycle and `pass_count` increments.
  - If `loop`=1: the seed increments by 1, the error state clears, and the engine proceeds directly to W_SETUP with `busy` held high.
  - Otherwise the engine returns to IDLE.
- `start` while busy is ignored. `mode` and `seed` changes mid-run have no effect.

## Timing
- Reset values:
  - `sram_addr`=0, `sram_dq_o`=0, `sram_dq_oe`=0.
  - `cs_n`=1, `oe_n`=1, `we_n`=1.
  - `busy`=0, `done`=0, `err`=0.
  - `err_count`, `fail_*`, `pass_count` = 0.
- `busy` rises on the edge after `start` is seen in IDLE. The first W_SETUP is that same cycle.
- Write cost per word: WAIT_CYCLES+2 cycles. Read cost per word: WAIT_CYCLES+1 cycles.
- Run length: 2·2^ADDR_W·(2·WAIT_CYCLES+3) + 2 TURN + 1 FIN cycles.
- `done` is asserted in the FIN cycle; `busy` falls the following edge (non-loop).
- `err`, `err_count` and `fail_*` update on the edge following the sample edge.
- If reset asserts mid-run, all outputs take reset values immediately (asynchronously). The SRAM bus is released, with no partial write pulse left low.

## Test plan
- ADDR_W=4, DATA_W=8, WAIT_CYCLES=1, ideal SRAM model, mode 0, seed 0x10, start pulse -> `done` after 2·16·5+3=163 cycles; `err`=0, `err_count`=0, `pass_count`=1; model holds `~(0x10+a)`.
- Same run with model bit 3 stuck-at-0 at address 5 -> exactly one mismatch (phase 0 writes 0x15, bit 3 = 0, passes; phase 1 writes 0xEA, bit 3 = 1, fails). Expected `err_count`=1, `fail_addr`=5, `fail_exp`=0xEA, `fail_got`=0xE2.
- Model with all data stuck-at-0, mode 1 -> `err_count`=32. `fail_*` hold the first failure only: addr 0, exp = seed.
- Protocol monitor on all modes with WAIT_CYCLES=3:
  - `we_n` low pulses last exactly 3 cycles, with addr/data stable from one cycle before to one cycle after.
  - `oe_n`=0 never overlaps `dq_oe`=1.
- `loop`=1 for three runs -> three `done` pulses; seed observed as s, s+1, s+2; `busy` stays 1 throughout; `pass_count`=3.
- Assert `rst_n` low mid-W_PULSE -> `we_n`, `cs_n`, `oe_n`=1 and `dq_oe`=0 in the same cycle; a `start` pulse after release runs a clean pass.
